// File: rtl/bram_rd_sched.sv
// Round-robin scheduler sharing one BRAM read port among NUM_REQ requesters.
// One read in flight at a time, with a watchdog; the result returns only to the requester that issued it.
module bram_rd_sched #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      RD_START,
  output logic [ADDR_W-1:0]         RD_ADDR,
  input  logic [DATA_W-1:0]         RD_DATA,
  input  logic                      RD_DONE,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic                      spurious_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = WD_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t              state_q, state_d;
  logic [2:0]          last_q;
  logic [2:0]          id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                err_q;
  logic [15:0]         cnt_q;
  logic                spur_q;

  logic                pick_vld;
  logic [2:0]          pick_id;
  logic [2:0]          idx;
  logic                wd_fire;
  logic                accept;

  // Search starts just after the last served requester, so the previous winner ranks last.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = 3'd0;
    idx      = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 3'((int'(last_q) + k) % NUM_REQ);
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  assign accept  = (state_q == S_IDLE) && pick_vld;
  assign wd_fire = WD_EN && (cnt_q == TO_LAST);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick_id] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[id_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (RD_DONE || wd_fire) state_d = S_RESP;
      S_RESP:  if (rsp_ready[id_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= 3'(NUM_REQ - 1);
      id_q   <= 3'd0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            id_q   <= pick_id;
            addr_q <= req_addr[int'(pick_id)*ADDR_W +: ADDR_W];
          end
        end
        S_ISSUE: cnt_q <= 16'd0;
        S_WAIT: begin
          // Completion takes precedence over a watchdog expiring in the same cycle.
          if (RD_DONE) begin
            data_q <= RD_DATA;
            err_q  <= 1'b0;
          end else if (wd_fire) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RESP: if (rsp_ready[id_q]) last_q <= id_q;
        default: ;
      endcase
    end
  end

  // Completions outside WAIT (including late ones after an abort) are dropped but remembered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             spur_q <= 1'b0;
    else if (RD_DONE && state_q != S_WAIT) spur_q <= 1'b1;
  end

  assign rsp_data      = data_q;
  assign rsp_err       = err_q;
  assign RD_START      = (state_q == S_ISSUE);
  assign RD_ADDR       = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign grant_id      = id_q;
  assign spurious_done = spur_q;

endmodule

// File: tb/tb_bram_rd_sched.sv
// Bench for bram_rd_sched: table-driven arbitration vectors, hand-written corner sequences,
// and a response scoreboard fed when read completions are driven.
module tb_bram_rd_sched;
  localparam int N  = 5;
  localparam int AW = 32;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   RD_DATA;
  logic            RD_DONE;

  logic [N-1:0]  req_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err, RD_START, busy, spurious_done;
  logic [AW-1:0] RD_ADDR;
  logic [2:0]    grant_id;

  logic [N-1:0]  req_ready_b, rsp_valid_b;
  logic [DW-1:0] rsp_data_b;
  logic          rsp_err_b, RD_START_b, busy_b, spurious_done_b;
  logic [AW-1:0] RD_ADDR_b;
  logic [2:0]    grant_id_b;

  bram_rd_sched #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .RD_START(RD_START), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_DONE(RD_DONE),
    .busy(busy), .grant_id(grant_id), .spurious_done(spurious_done)
  );

  bram_rd_sched #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
    .RD_START(RD_START_b), .RD_ADDR(RD_ADDR_b), .RD_DATA(RD_DATA), .RD_DONE(RD_DONE),
    .busy(busy_b), .grant_id(grant_id_b), .spurious_done(spurious_done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]    id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  typedef struct {
    logic [N-1:0]  valid;
    int            exp_id;
    int            dly;
    logic [DW-1:0] data;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h40 + 32'(i) * 32'h60;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int id, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.id   = 3'(id);
    x.data = d;
    x.err  = e;
    sbq.push_back(x);
  endtask

  // A response handshake completes at the next rising edge; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (rsp_valid & rsp_ready) != '0) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got rsp_valid=%0h expected no response", rsp_valid);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_valid", DW'(rsp_valid), DW'(oh(int'(mon_e.id))));
        chk("sb_data", rsp_data, mon_e.data);
        chk("sb_err", DW'(rsp_err), DW'(mon_e.err));
      end
    end
  end

  task automatic do_xact(input string nm, input logic [N-1:0] v, input int exp_id,
                         input int dly, input logic [DW-1:0] d);
    req_valid = v;
    #1;
    chk({nm, "_ready"}, DW'(req_ready), DW'(oh(exp_id)));
    step;
    req_valid = '0;
    chk({nm, "_issue"}, DW'({RD_START, busy, grant_id, RD_ADDR}),
        DW'({1'b1, 1'b1, 3'(exp_id), addr_of(exp_id)}));
    repeat (dly + 1) step;
    RD_DONE = 1'b1;
    RD_DATA = d;
    push(exp_id, d, 1'b0);
    step;
    RD_DONE = 1'b0;
    chk({nm, "_rsp"}, DW'({busy, rsp_valid}), DW'({1'b1, oh(exp_id)}));
    step;
    chk({nm, "_idle"}, DW'({busy, RD_START}), '0);
  endtask

  logic [DW-1:0] d_a5, d_bp1, d_bp3, d_co;

  initial begin
    tbl[0] = '{5'b11111, 3, 0, {4{32'hD000_0000}}};
    tbl[1] = '{5'b11111, 4, 2, {4{32'hD111_1111}}};
    tbl[2] = '{5'b00011, 0, 1, {4{32'hD222_2222}}};
    tbl[3] = '{5'b00101, 2, 0, {4{32'hD333_3333}}};
    tbl[4] = '{5'b00001, 0, 5, {4{32'hD444_4444}}};
    tbl[5] = '{5'b10000, 4, 0, {4{32'hD555_5555}}};
    tbl[6] = '{5'b01001, 0, 0, {4{32'hD666_6666}}};
    tbl[7] = '{5'b01000, 3, 3, {4{32'hD777_7777}}};
    d_a5  = {16{8'hA5}};
    d_bp1 = {4{32'hB1B1_0001}};
    d_bp3 = {4{32'hB3B3_0003}};
    d_co  = {4{32'hC0C0_1234}};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    RD_DONE   = 1'b0;
    RD_DATA   = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_of(i);
    #1 rst = 1'b0;
    step;
    step;
    chk("reset_ctl", DW'({req_ready, rsp_valid, rsp_err, RD_START, busy, grant_id, spurious_done}), '0);
    chk("reset_data", rsp_data, '0);
    chk("reset_addr", DW'(RD_ADDR), '0);
    rst = 1'b1;
    step;

    // Round robin: all requesters held valid, completion in the first WAIT cycle.
    req_valid = 5'b11111;
    rsp_ready = 5'b11111;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk($sformatf("rr%0d_ready", g), DW'(req_ready), DW'(oh(g % N)));
      step;
      chk($sformatf("rr%0d_issue", g), DW'({RD_START, grant_id}), DW'({1'b1, 3'(g % N)}));
      if (g == 5) req_valid = '0;
      step;
      RD_DONE = 1'b1;
      RD_DATA = {4{32'hC0DE_0000 + 32'(g)}};
      push(g % N, RD_DATA, 1'b0);
      step;
      RD_DONE = 1'b0;
      chk($sformatf("rr%0d_rsp", g), DW'(rsp_valid), DW'(oh(g % N)));
      step;
    end

    do_xact("single", 5'b00100, 2, 2, d_a5);

    for (int i = 0; i < 8; i++)
      do_xact($sformatf("vec%0d", i), tbl[i].valid, tbl[i].exp_id, tbl[i].dly, tbl[i].data);

    // Response backpressure with another requester waiting.
    req_valid = 5'b00010;
    #1;
    chk("bp_ready", DW'(req_ready), DW'(oh(1)));
    step;
    req_valid = 5'b01000;
    chk("bp_issue", DW'({grant_id, RD_ADDR}), DW'({3'd1, addr_of(1)}));
    step;
    RD_DONE   = 1'b1;
    RD_DATA   = d_bp1;
    rsp_ready = 5'b11101;
    push(1, d_bp1, 1'b0);
    step;
    RD_DONE = 1'b0;
    RD_DATA = '0;
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold%0d", c), DW'({rsp_valid, RD_START, req_ready}), DW'({oh(1), 1'b0, 5'b0}));
      chk($sformatf("bp_data%0d", c), rsp_data, d_bp1);
      step;
    end
    rsp_ready = 5'b11111;
    step;
    chk("bp_next_ready", DW'(req_ready), DW'(oh(3)));
    step;
    req_valid = '0;
    chk("bp_next_issue", DW'({RD_START, grant_id, RD_ADDR}), DW'({1'b1, 3'd3, addr_of(3)}));
    step;
    RD_DONE = 1'b1;
    RD_DATA = d_bp3;
    push(3, d_bp3, 1'b0);
    step;
    RD_DONE = 1'b0;
    step;

    // Reset asserted in WAIT aborts the read; requester 0 then outranks requester 4.
    req_valid = 5'b00100;
    #1;
    chk("rst_ready", DW'(req_ready), DW'(oh(2)));
    step;
    req_valid = '0;
    step;
    step;
    chk("rst_inwait", DW'({busy, RD_START, rsp_valid}), DW'({1'b1, 1'b0, 5'b0}));
    rst = 1'b0;
    #1;
    chk("rst_async_ctl", DW'({req_ready, rsp_valid, rsp_err, RD_START, busy, grant_id, spurious_done}), '0);
    chk("rst_async_data", rsp_data, '0);
    chk("rst_async_addr", DW'(RD_ADDR), '0);
    step;
    step;
    rst       = 1'b1;
    req_valid = 5'b10001;
    #1;
    chk("rst_prio", DW'(req_ready), DW'(oh(0)));
    step;
    req_valid = '0;
    chk("rst_prio_issue", DW'({grant_id, RD_ADDR}), DW'({3'd0, addr_of(0)}));
    step;
    RD_DONE = 1'b1;
    RD_DATA = {4{32'h0F0F_5A5A}};
    push(0, RD_DATA, 1'b0);
    step;
    RD_DONE = 1'b0;
    step;

    // Watchdog (TIMEOUT=8): abort after the eighth WAIT cycle, then a late completion.
    req_valid = 5'b10000;
    #1;
    chk("wd_ready", DW'(req_ready), DW'(oh(4)));
    push(4, '0, 1'b1);
    step;
    req_valid = '0;
    for (int c = 1; c <= 8; c++) begin
      step;
      chk($sformatf("wd_wait%0d", c), DW'({busy, rsp_valid}), DW'({1'b1, 5'b0}));
    end
    step;
    chk("wd_rsp", DW'({rsp_valid, rsp_err}), DW'({oh(4), 1'b1}));
    chk("wd_data", rsp_data, '0);
    step;
    chk("wd_spur0", DW'(spurious_done), '0);
    RD_DONE = 1'b1;
    RD_DATA = {4{32'hDEAD_BEEF}};
    step;
    RD_DONE = 1'b0;
    chk("wd_spur1", DW'({spurious_done, busy, rsp_valid}), DW'({1'b1, 1'b0, 5'b0}));
    repeat (3) step;
    chk("wd_spur_sticky", DW'(spurious_done), DW'(1'b1));

    rst = 1'b0;
    step;
    rst = 1'b1;
    chk("spur_clr", DW'(spurious_done), '0);

    // Completion in the same cycle the TIMEOUT=4 watchdog would expire.
    req_valid = 5'b00010;
    #1;
    chk("co_ready", DW'(req_ready_b), DW'(oh(1)));
    step;
    req_valid = '0;
    repeat (4) step;
    chk("co_wait4", DW'({busy_b, rsp_valid_b}), DW'({1'b1, 5'b0}));
    RD_DONE = 1'b1;
    RD_DATA = d_co;
    push(1, d_co, 1'b0);
    step;
    RD_DONE = 1'b0;
    chk("co_rsp", DW'({rsp_valid_b, rsp_err_b}), DW'({oh(1), 1'b0}));
    chk("co_data", rsp_data_b, d_co);
    step;
    step;

    chk("sb_empty", DW'(sbq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bram_rd_sched.md
# bram_rd_sched

Synchronous round-robin scheduler that shares the single BRAM read port (RD_START/RD_ADDR/RD_DATA/RD_DONE) among NUM_REQ stream-instruction requesters. Each requester presents a read address with a valid/ready handshake. The block issues one BRAM read at a time, waits for completion (with a watchdog), and routes the 128-bit result back only to the requester that issued it. It sits between the stream-instruction fetch units and the BRAM read interface.

## Interface
- NUM_REQ, 5, number of requesters (2..8)
- ADDR_W, 32, read address width
- DATA_W, 128, read data width
- TIMEOUT, 1023, max WAIT cycles before abort; 0 disables the watchdog
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid&ready are high at the edge
- rsp_valid  out  NUM_REQ  one-hot response valid to the owning requester
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  DATA_W  response data, shared bus
- rsp_err  out  1  response is a watchdog abort; rsp_data=0
- RD_START  out  1  one-cycle BRAM read pulse
- RD_ADDR  out  ADDR_W  BRAM read address, held from ISSUE until the return to IDLE
- RD_DATA  in  DATA_W  BRAM read data, valid with RD_DONE
- RD_DONE  in  1  one-cycle BRAM completion pulse
- busy  out  1  state != IDLE
- grant_id  out  3  index of the current/last granted requester
- spurious_done  out  1  sticky: RD_DONE seen outside WAIT; cleared only by reset

## Operation
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE
  - Arbiter picks the first i with req_valid[i], searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready is combinational: the one-hot of the pick while in IDLE, else 0.
  - At the edge: latch addr and id, set grant_id, go to ISSUE.
  - A requester may drop req_valid before acceptance; nothing is latched for it.
- ISSUE: RD_START=1 for exactly one cycle with RD_ADDR=latched address. Next state is WAIT. Watchdog counter clears.
- WAIT
  - On RD_DONE: capture RD_DATA into rsp_data, rsp_err=0, go to RESP.
  - Else the counter increments. When TIMEOUT!=0 and counter==TIMEOUT-1 without RD_DONE: rsp_data=0, rsp_err=1, go to RESP.
- RESP
  - rsp_valid[id]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[id] at the edge: clear rsp_valid, set last_grant=id, go to IDLE.
  - rsp_ready of other requesters is ignored.
- RD_DONE in IDLE, ISSUE or RESP: data ignored, spurious_done set to 1. An RD_DONE that arrives late after a timeout is handled the same way.
- Simultaneous RD_DONE and the timeout cycle: RD_DONE wins (rsp_err=0).
- Pointer after reset: last_grant=NUM_REQ-1, so requester 0 has top priority first.
- Counter is 16 bits and saturates. It does not wrap.

## Timing
- Reset values: all outputs 0 (req_ready, rsp_valid, rsp_data, rsp_err, RD_START, RD_ADDR, busy, grant_id, spurious_done). State=IDLE, last_grant=NUM_REQ-1.
- Reset asserted mid-operation aborts immediately: state returns to IDLE and outputs go to reset values. No response is delivered for the aborted request.
- Accept at edge T → RD_START high in cycle T+1.
- RD_DONE sampled at edge D → rsp_valid high from D+1.
- rsp_ready at edge R → IDLE in R+1, earliest next accept at R+1.
- Minimum request-to-request period: 4 cycles, given RD_DONE in the first WAIT cycle and rsp_ready held high.
- busy is high from T+1 through the RESP cycle. It is 0 in IDLE.

## Test plan
- Single read: req_valid[2]=1, addr 0x100; RD_DONE 3 cycles after RD_START with data 0xA5..A5. Expect: req_ready[2] pulse; RD_START one cycle with RD_ADDR=0x100; rsp_valid[2]=1 with data 0xA5..A5 and rsp_err=0; grant_id=2.
- Round robin: all 5 req_valid held high, immediate RD_DONE, rsp_ready all high. Expect grant order 0,1,2,3,4,0, each grant 4 cycles apart.
- Backpressure: rsp_ready[1]=0 for 10 cycles during RESP while req_valid[3]=1. Expect rsp_valid[1] and data stable for 10 cycles, no RD_START, and req 3 accepted only after the rsp_ready[1] edge.
- Watchdog: TIMEOUT=8 and no RD_DONE. Expect rsp_err=1 and rsp_data=0 at WAIT cycle 8. A late RD_DONE afterwards sets spurious_done=1.
- Reset mid-WAIT: drive rst low in WAIT. Expect all outputs 0 asynchronously. After release, requester 0 wins over a simultaneous requester 4.
- Coincident RD_DONE and timeout cycle (TIMEOUT=4, RD_DONE on WAIT cycle 4). Expect rsp_err=0 with the captured RD_DATA.
